aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 126 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: stores the key schedule from an external expansion
// function and steps a shared external round datapath for encrypt or decrypt.
module aes_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load_i,
  input  logic [127:0] key_i,
  output logic         key_ready_o,
  output logic [3:0]   ke_rc_o,
  output logic [127:0] ke_prev_o,
  input  logic [127:0] ke_next_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         in_dec_i,
  input  logic [127:0] in_data_i,
  output logic [3:0]   dp_rc_o,
  output logic         dp_dec_o,
  output logic         dp_last_o,
  output logic [127:0] dp_state_o,
  output logic [127:0] dp_key_o,
  input  logic [127:0] dp_next_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] KEXP  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   kcnt_q, kcnt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         key_ready_q, key_ready_d;
  logic         dec_q, dec_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q [0:10];
  logic         load_go, accept, in_round;
  logic [3:0]   rk_sel;

  assign load_go    = (fsm_q == IDLE) && key_load_i;
  assign in_ready_o = (fsm_q == IDLE) && key_ready_q && !key_load_i;
  assign accept     = in_valid_i && in_ready_o;
  assign in_round   = (fsm_q == ROUND);

  always_comb begin
    fsm_d       = fsm_q;
    kcnt_d      = kcnt_q;
    rnd_d       = rnd_q;
    key_ready_d = key_ready_q;
    dec_d       = dec_q;
    st_d        = st_q;
    case (fsm_q)
      IDLE: begin
        if (load_go) begin
          key_ready_d = 1'b0;
          kcnt_d      = 4'd1;
          fsm_d       = KEXP;
        end else if (accept) begin
          st_d  = in_data_i ^ (in_dec_i ? rk_q[10] : rk_q[0]);
          rnd_d = 4'd1;
          dec_d = in_dec_i;
          fsm_d = ROUND;
        end
      end
      KEXP: begin
        kcnt_d = kcnt_q + 4'd1;
        if (kcnt_q == 4'd10) begin
          kcnt_d      = 4'd0;
          key_ready_d = 1'b1;
          fsm_d       = IDLE;
        end
      end
      ROUND: begin
        st_d  = dp_next_i;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          rnd_d = 4'd0;
          fsm_d = DONE;
        end
      end
      default: begin
        if (out_ready_i) fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      kcnt_q      <= 4'd0;
      rnd_q       <= 4'd0;
      key_ready_q <= 1'b0;
      dec_q       <= 1'b0;
      st_q        <= '0;
    end else begin
      fsm_q       <= fsm_d;
      kcnt_q      <= kcnt_d;
      rnd_q       <= rnd_d;
      key_ready_q <= key_ready_d;
      dec_q       <= dec_d;
      st_q        <= st_d;
    end
  end

  // Schedule storage is left unreset; key_ready guards every use of it.
  always_ff @(posedge clk) begin
    if (load_go)
      rk_q[0] <= key_i;
    else if (fsm_q == KEXP)
      rk_q[kcnt_q] <= ke_next_i;
  end

  assign rk_sel = dec_q ? (4'd10 - rnd_q) : rnd_q;

  assign key_ready_o = key_ready_q;
  assign ke_rc_o     = (fsm_q == KEXP) ? kcnt_q : 4'd0;
  assign ke_prev_o   = (fsm_q == KEXP) ? rk_q[kcnt_q - 4'd1] : '0;
  assign dp_rc_o     = in_round ? rnd_q : 4'd0;
  assign dp_last_o   = in_round && (rnd_q == 4'd10);
  assign dp_key_o    = in_round ? rk_q[rk_sel] : '0;
  assign dp_dec_o    = dec_q;
  assign dp_state_o  = st_q;
  assign out_valid_o = (fsm_q == DONE);
  assign out_data_o  = out_valid_o ? st_q : '0;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: supplies AES key-expansion and round functions,
// checks results against a whole-cipher reference and known FIPS-197 vectors.
module tb_aes_round_ctrl;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         key_load = 1'b0, key_ready;
  logic [127:0] key = '0, ke_prev, ke_next;
  logic [3:0]   ke_rc, dp_rc;
  logic         in_valid = 1'b0, in_ready, in_dec = 1'b0;
  logic [127:0] in_data = '0;
  logic         dp_dec, dp_last;
  logic [127:0] dp_state, dp_key, dp_next;
  logic         out_valid, out_ready = 1'b0;
  logic [127:0] out_data;

  int total = 0, bad = 0;
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  typedef logic [10:0][127:0] sched_t;
  typedef struct {
    logic [127:0] key;
    logic [127:0] din;
    logic         dec;
    logic [127:0] exp;
    int           stall;
    int           inj;   // edge after accept at which key_load is pulsed, -1 = none
  } vec_t;
  vec_t tbl [4];
  logic [127:0] cur_key;
  logic [127:0] key_s [10];

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .key_load_i(key_load), .key_i(key), .key_ready_o(key_ready),
    .ke_rc_o(ke_rc), .ke_prev_o(ke_prev), .ke_next_i(ke_next),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_dec_i(in_dec), .in_data_i(in_data),
    .dp_rc_o(dp_rc), .dp_dec_o(dp_dec), .dp_last_o(dp_last),
    .dp_state_o(dp_state), .dp_key_o(dp_key), .dp_next_i(dp_next),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] coef(input logic inv, input int idx);
    case (idx)
      0:       return inv ? 8'd14 : 8'd2;
      1:       return inv ? 8'd11 : 8'd3;
      2:       return inv ? 8'd13 : 8'd1;
      default: return inv ? 8'd9  : 8'd1;
    endcase
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? isbox[gb(s, i)] : sbox[gb(s, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = gb(s, r + 4*src);
      end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0] acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gm(gb(s, k + 4*c), coef(inv, (k - r + 4) % 4));
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] dp_round(input logic [127:0] s, input logic [127:0] k,
                                            input logic dec, input logic last);
    logic [127:0] t;
    if (!dec) begin
      t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (!last) t = mix(t, 1'b0);
      return t ^ k;
    end
    t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
    if (!last) t = mix(t, 1'b1);
    return t;
  endfunction

  function automatic logic [127:0] ke_step(input logic [127:0] prev, input logic [3:0] rc);
    logic [7:0]  rcv;
    logic [31:0] w3, rot, sw, n0, n1, n2;
    rcv = 8'h01;
    for (int i = 1; i < int'(rc); i++) rcv = xt(rcv);
    w3  = prev[31:0];
    rot = {w3[23:0], w3[31:24]};
    sw  = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]} ^ {rcv, 24'h0};
    n0  = prev[127:96] ^ sw;
    n1  = prev[95:64] ^ n0;
    n2  = prev[63:32] ^ n1;
    return {n0, n1, n2, w3 ^ n2};
  endfunction

  function automatic sched_t expand(input logic [127:0] k0);
    sched_t k;
    k[0] = k0;
    for (int i = 1; i <= 10; i++) k[i] = ke_step(k[i-1], 4'(i));
    return k;
  endfunction

  // Full cipher in the textbook order: whitening key, then ten rounds.
  function automatic logic [127:0] ref_cipher(input logic [127:0] k0, input logic [127:0] din,
                                              input logic dec);
    sched_t k;
    logic [127:0] s;
    k = expand(k0);
    s = din ^ (dec ? k[10] : k[0]);
    for (int r = 1; r <= 10; r++) s = dp_round(s, dec ? k[10-r] : k[r], dec, r == 10);
    return s;
  endfunction

  assign ke_next = ke_step(ke_prev, ke_rc);
  assign dp_next = dp_round(dp_state, dp_key, dp_dec, dp_last);

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_key(input logic [127:0] k);
    int n, kerr, ov;
    key_load = 1'b1; key = k;
    #1 chk("in_ready_during_key_load", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    key_load = 1'b0; in_valid = 1'b0; key = rnd128();
    n = 0; kerr = 0; ov = 0;
    while (!key_ready && n < 20) begin
      if (ke_rc !== 4'(n + 1)) kerr++;
      if (out_valid) ov++;
      @(posedge clk); #1; n++;
    end
    chk("kexp_latency", 128'(n), 128'(10));
    chk("ke_rc_seq_errs", 128'(kerr), 128'(0));
    chk("no_out_during_kexp", 128'(ov), 128'(0));
    chk("ke_rc_idle", 128'(ke_rc), 128'(0));
    cur_key = k;
  endtask

  task automatic run_block(input logic [127:0] din, input logic dec, input logic [127:0] exp,
                           input int stall, input int inj);
    sched_t k;
    int n, rc_bad, last_bad, key_bad, hold_bad;
    k = expand(cur_key);
    in_data = din; in_dec = dec; in_valid = 1'b1;
    #1 n = 0;
    while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_accept", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_dec = ~dec; in_data = rnd128();
    n = 0; rc_bad = 0; last_bad = 0; key_bad = 0;
    for (int i = 0; i < 10; i++) key_s[i] = '0;
    while (!out_valid && n < 20) begin
      if (n < 10) begin
        if (dp_rc !== 4'(n + 1)) rc_bad++;
        if (dp_last !== (n == 9)) last_bad++;
        if (dp_key !== (dec ? k[9-n] : k[n+1])) key_bad++;
        key_s[n] = dp_key;
      end
      key_load = (n == inj);
      if (key_load) key = rnd128();
      @(posedge clk); #1; n++;
    end
    key_load = 1'b0;
    chk("round_latency", 128'(n), 128'(10));
    chk("dp_rc_seq_errs", 128'(rc_bad), 128'(0));
    chk("dp_last_seq_errs", 128'(last_bad), 128'(0));
    chk("dp_key_seq_errs", 128'(key_bad), 128'(0));
    chk("out_data", out_data, exp);
    hold_bad = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) hold_bad++;
    end
    if (stall > 0) chk("stall_hold_errs", 128'(hold_bad), 128'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_handshake", 128'(out_valid), 128'(0));
    chk("key_ready_kept", 128'(key_ready), 128'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] inv, sv;
    int n, leak;
    logic [127:0] fk, pt, ct, zk, k2, d, e;
    logic dd;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sv = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = sv;
      isbox[sv] = 8'(x);
    end
    fk = 128'h000102030405060708090a0b0c0d0e0f;
    pt = 128'h00112233445566778899aabbccddeeff;
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    zk = '0;
    tbl[0] = '{key: fk, din: pt, dec: 1'b0, exp: ct, stall: 0, inj: -1};
    tbl[1] = '{key: fk, din: ct, dec: 1'b1, exp: pt, stall: 5, inj: -1};
    tbl[2] = '{key: zk, din: '0, dec: 1'b0, exp: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, stall: 2, inj: -1};
    tbl[3] = '{key: zk, din: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, dec: 1'b1, exp: '0, stall: 0, inj: 3};
    cur_key = '1;

    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", 128'(key_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_dp_rc", 128'(dp_rc), 128'(0));
    chk("rst_ke_rc", 128'(ke_rc), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_key_in_ready", 128'(in_ready), 128'(0));

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].key !== cur_key) load_key(tbl[i].key);
      run_block(tbl[i].din, tbl[i].dec, tbl[i].exp, tbl[i].stall, tbl[i].inj);
      if (i == 0) chk("rk10_fips", key_s[9], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    end

    // key_load collides with a pending block: expansion wins, block is dropped.
    in_valid = 1'b1; in_data = pt; in_dec = 1'b0;
    load_key(fk);
    run_block(pt, 1'b0, ct, 0, -1);

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        k2 = rnd128();
        load_key(k2);
      end
      d  = rnd128();
      dd = 1'($urandom_range(0, 1));
      e  = ref_cipher(cur_key, d, dd);
      run_block(d, dd, e, $urandom_range(0, 3), (i == 3) ? 6 : -1);
    end

    // Asynchronous reset in the middle of round 5.
    in_valid = 1'b1; in_data = pt; in_dec = 1'b0;
    #1 @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (dp_rc !== 4'd5 && n < 20) begin @(posedge clk); #1; n++; end
    chk("reach_round5", 128'(dp_rc), 128'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_out_data", out_data, '0);
    chk("arst_dp_rc", 128'(dp_rc), 128'(0));
    chk("arst_dp_key", dp_key, '0);
    chk("arst_key_ready", 128'(key_ready), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    leak = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (in_ready || out_valid) leak++;
    end
    chk("post_reset_no_accept", 128'(leak), 128'(0));
    in_valid = 1'b0;
    load_key(fk);
    run_block(pt, 1'b0, ct, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
